box_raster_engine: RTL

- Rasterises rectangular sprite draw/erase requests from the game control FSM into a serial stream of single-pixel writes.
- The stream drives the x/y/colour/plot inputs of vga_adapter, which runs at 160x120 with 3-bit colour.
- Sits directly downstream of the player/obstacle state machine and upstream of vga_adapter.
- Replaces counter-driven per-state drawing with a buffered, handshaked pixel engine that clips to the screen.

---
 rtl/box_raster_engine.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/box_raster_engine.sv
// Rectangle rasteriser: buffers box draw/erase requests and streams one clipped pixel write
// per clock to the VGA adapter, row-major, with a done pulse after each box.
module box_raster_engine #(
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [3:0] req_w,
  input  logic [3:0] req_h,
  input  logic [2:0] req_colour,
  input  logic       req_erase,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [8:0] ScreenW = 9'(SCREEN_W);
  localparam logic [7:0] ScreenH = 8'(SCREEN_H);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [3:0] w;
    logic [3:0] h;
    logic [2:0] colour;
    logic       erase;
  } req_t;

  typedef enum logic [1:0] {StIdle, StLoad, StPlot} state_e;

  req_t            mem_q [FIFO_DEPTH];
  req_t            head_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push, pop;

  state_e     state_q;
  logic [7:0] base_x_q;
  logic [6:0] base_y_q;
  logic [3:0] w_q, h_q, col_q, row_q;
  logic [2:0] fill_q;
  logic       last_q;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  assign req_ready = (count_q != Full);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);

  // Wide sums so that coordinates past the right/bottom edge (or wrapping past 255) clip.
  assign sum_x = {1'b0, base_x_q} + {5'b0, col_q};
  assign sum_y = {1'b0, base_y_q} + {4'b0, row_q};

  assign busy = (state_q != StIdle) || (count_q != '0) || plot || last_q;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {req_x, req_y, req_w, req_h, req_colour, req_erase};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      head_q   <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
      fill_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      last_q   <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      done     <= 1'b0;
    end else begin
      plot   <= 1'b0;
      last_q <= 1'b0;
      done   <= last_q;
      case (state_q)
        StIdle: begin
          if (pop) begin
            head_q  <= mem_q[rd_ptr_q];
            state_q <= StLoad;
          end
        end
        StLoad: begin
          base_x_q <= head_q.x;
          base_y_q <= head_q.y;
          w_q      <= head_q.w;
          h_q      <= head_q.h;
          fill_q   <= head_q.erase ? 3'b000 : head_q.colour;
          col_q    <= '0;
          row_q    <= '0;
          state_q  <= StPlot;
        end
        StPlot: begin
          x      <= sum_x[7:0];
          y      <= sum_y[6:0];
          colour <= fill_q;
          plot   <= (sum_x < ScreenW) && (sum_y < ScreenH);
          if (col_q == w_q) begin
            col_q <= '0;
            if (row_q == h_q) begin
              state_q <= StIdle;
              last_q  <= 1'b1;
            end else begin
              row_q <= row_q + 4'd1;
            end
          end else begin
            col_q <= col_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
